// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl
// Description : Main control FSM for a multi-cycle RISC-V core. It sequences
//               the shared ALU and the unified instruction/data memory
//               through fetch, decode, execute, memory and writeback states.
//               A wait counter bounds every memory handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
  parameter int MEM_WAIT_MAX = 15  // 0 disables the memory timeout
) (
  input  logic       clk_i,
  input  logic       rst_n,
  input  logic [6:0] opcode_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       PCWrite_o,
  output logic       IRWrite_o,
  output logic       IorD_o,
  output logic       MemRead_o,
  output logic       MemWrite_o,
  output logic       RegWrite_o,
  output logic [1:0] MemtoReg_o,
  output logic [1:0] ALUSrcA_o,
  output logic [1:0] ALUSrcB_o,
  output logic [1:0] ALUop_o,
  output logic [1:0] PCSource_o,
  output logic       instr_done_o,
  output logic       illegal_o,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC_R  = 4'd6,
    S_EXEC_I  = 4'd7,
    S_ALUWB   = 4'd8,
    S_BRANCH  = 4'd9,
    S_JAL     = 4'd10,
    S_JALR    = 4'd11,
    S_ILLEGAL = 4'd12
  } state_t;

  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] c_OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [3:0] c_WAIT_MAX  = 4'(MEM_WAIT_MAX);

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_wait_cnt;
  logic       w_mem_state;
  logic       w_timeout;

  // Only the three handshake states wait on memory; everywhere else
  // mem_ready_i is ignored.
  assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMRD) ||
                       (r_state == S_MEMWR);
  assign w_timeout   = (MEM_WAIT_MAX != 0) && w_mem_state && !mem_ready_i &&
                       (r_wait_cnt == c_WAIT_MAX);
  assign state_o     = r_state;

  // Next-state selection; a memory timeout overrides the normal transition.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  w_next = mem_ready_i ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode_i)
          c_OP_LOAD, c_OP_STORE: w_next = S_MEMADR;
          c_OP_RTYPE:            w_next = S_EXEC_R;
          c_OP_ITYPE:            w_next = S_EXEC_I;
          c_OP_BRANCH:           w_next = S_BRANCH;
          c_OP_JAL:              w_next = S_JAL;
          c_OP_JALR:             w_next = S_JALR;
          default:               w_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR:  w_next = (opcode_i == c_OP_LOAD) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   w_next = mem_ready_i ? S_MEMWB : S_MEMRD;
      S_MEMWB:   w_next = S_FETCH;
      S_MEMWR:   w_next = mem_ready_i ? S_FETCH : S_MEMWR;
      S_EXEC_R:  w_next = S_ALUWB;
      S_EXEC_I:  w_next = S_ALUWB;
      S_ALUWB:   w_next = S_FETCH;
      S_BRANCH:  w_next = S_FETCH;
      S_JAL:     w_next = S_FETCH;
      S_JALR:    w_next = S_FETCH;
      S_ILLEGAL: w_next = S_ILLEGAL;
      default:   w_next = S_FETCH;  // unused encodings recover to fetch
    endcase
    if (w_timeout) begin
      w_next = S_ILLEGAL;
    end
  end

  // State register and memory wait counter. The counter only advances while
  // a memory state is held without ready, so it is zero on entry to each one.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_FETCH;
      r_wait_cnt <= 4'd0;
    end else begin
      r_state <= w_next;
      if (w_mem_state && !mem_ready_i && (w_next == r_state)) begin
        r_wait_cnt <= r_wait_cnt + 4'd1;
      end else begin
        r_wait_cnt <= 4'd0;
      end
    end
  end

  // Control outputs decoded from the current state (and the ready/zero
  // qualifiers where a state's enable depends on them).
  always_comb begin
    PCWrite_o    = 1'b0;
    IRWrite_o    = 1'b0;
    IorD_o       = 1'b0;
    MemRead_o    = 1'b0;
    MemWrite_o   = 1'b0;
    RegWrite_o   = 1'b0;
    MemtoReg_o   = 2'b00;
    ALUSrcA_o    = 2'b00;
    ALUSrcB_o    = 2'b00;
    ALUop_o      = 2'b00;
    PCSource_o   = 2'b00;
    instr_done_o = 1'b0;
    illegal_o    = 1'b0;
    case (r_state)
      S_FETCH: begin
        MemRead_o = 1'b1;
        ALUSrcB_o = 2'b01;
        IRWrite_o = mem_ready_i;
        PCWrite_o = mem_ready_i;
      end
      S_DECODE: begin
        ALUSrcA_o = 2'b10;
        ALUSrcB_o = 2'b10;
      end
      S_MEMADR: begin
        ALUSrcA_o = 2'b01;
        ALUSrcB_o = 2'b10;
      end
      S_MEMRD: begin
        MemRead_o = 1'b1;
        IorD_o    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite_o   = 1'b1;
        MemtoReg_o   = 2'b01;
        instr_done_o = 1'b1;
      end
      S_MEMWR: begin
        MemWrite_o   = 1'b1;
        IorD_o       = 1'b1;
        instr_done_o = mem_ready_i;
      end
      S_EXEC_R: begin
        ALUSrcA_o = 2'b01;
        ALUop_o   = 2'b10;
      end
      S_EXEC_I: begin
        ALUSrcA_o = 2'b01;
        ALUSrcB_o = 2'b10;
        ALUop_o   = 2'b11;
      end
      S_ALUWB: begin
        RegWrite_o   = 1'b1;
        instr_done_o = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA_o    = 2'b01;
        ALUop_o      = 2'b01;
        PCSource_o   = 2'b01;
        PCWrite_o    = zero_i;
        instr_done_o = 1'b1;
      end
      S_JAL: begin
        RegWrite_o   = 1'b1;
        MemtoReg_o   = 2'b10;
        PCWrite_o    = 1'b1;
        PCSource_o   = 2'b01;
        instr_done_o = 1'b1;
      end
      S_JALR: begin
        ALUSrcA_o    = 2'b01;
        ALUSrcB_o    = 2'b10;
        PCWrite_o    = 1'b1;
        RegWrite_o   = 1'b1;
        MemtoReg_o   = 2'b10;
        instr_done_o = 1'b1;
      end
      S_ILLEGAL: illegal_o = 1'b1;
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_ctrl
// Description : Self-checking bench for multicycle_ctrl: reset, a table of
//               single instructions, multi-cycle corner sequences, and a
//               randomized instruction stream against a phase-list model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_n;
  logic [6:0] opcode_i;
  logic       zero_i;
  logic       mem_ready_i;
  logic       PCWrite_o, IRWrite_o, IorD_o, MemRead_o, MemWrite_o, RegWrite_o;
  logic [1:0] MemtoReg_o, ALUSrcA_o, ALUSrcB_o, ALUop_o, PCSource_o;
  logic       instr_done_o, illegal_o;
  logic [3:0] state_o;

  int total = 0;
  int bad   = 0;

  multicycle_ctrl #(.MEM_WAIT_MAX(15)) u_dut (
    .clk_i(clk_i), .rst_n(rst_n), .opcode_i(opcode_i), .zero_i(zero_i),
    .mem_ready_i(mem_ready_i), .PCWrite_o(PCWrite_o), .IRWrite_o(IRWrite_o),
    .IorD_o(IorD_o), .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o),
    .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o), .ALUSrcA_o(ALUSrcA_o),
    .ALUSrcB_o(ALUSrcB_o), .ALUop_o(ALUop_o), .PCSource_o(PCSource_o),
    .instr_done_o(instr_done_o), .illegal_o(illegal_o), .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  // Packed view of every control output, in a fixed order.
  logic [17:0] w_act;
  assign w_act = {PCWrite_o, IRWrite_o, IorD_o, MemRead_o, MemWrite_o,
                  RegWrite_o, MemtoReg_o, ALUSrcA_o, ALUSrcB_o, ALUop_o,
                  PCSource_o, instr_done_o, illegal_o};

  // Expected control word for a given phase (state number), straight from
  // the per-state output rules.
  function automatic logic [17:0] exp_out(int ph, logic rdy, logic z);
    logic pcw, irw, iord, mr, mw, rw, done, ill;
    logic [1:0] m2r, sa, sb, op, pcs;
    {pcw, irw, iord, mr, mw, rw, done, ill} = '0;
    {m2r, sa, sb, op, pcs} = '0;
    case (ph)
      0:  begin mr = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
      1:  begin sa = 2'b10; sb = 2'b10; end
      2:  begin sa = 2'b01; sb = 2'b10; end
      3:  begin mr = 1; iord = 1; end
      4:  begin rw = 1; m2r = 2'b01; done = 1; end
      5:  begin mw = 1; iord = 1; done = rdy; end
      6:  begin sa = 2'b01; sb = 2'b00; op = 2'b10; end
      7:  begin sa = 2'b01; sb = 2'b10; op = 2'b11; end
      8:  begin rw = 1; done = 1; end
      9:  begin sa = 2'b01; op = 2'b01; pcs = 2'b01; pcw = z; done = 1; end
      10: begin rw = 1; m2r = 2'b10; pcw = 1; pcs = 2'b01; done = 1; end
      11: begin sa = 2'b01; sb = 2'b10; pcw = 1; rw = 1; m2r = 2'b10; done = 1; end
      12: ill = 1;
      default: ;
    endcase
    return {pcw, irw, iord, mr, mw, rw, m2r, sa, sb, op, pcs, done, ill};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [6:0] op;
    logic       z;
    int         cyc;   // cycles from FETCH to instr_done inclusive
    int         npcw;  // cycles with PCWrite=1
    int         nrw;   // cycles with RegWrite=1
  } vec_t;

  vec_t vecs[8];

  // Phase sequence of an instruction (state numbers), no wait states.
  function automatic void phases(input logic [6:0] op, output int q[$]);
    case (op)
      7'b0110011: q = '{0, 1, 6, 8};
      7'b0010011: q = '{0, 1, 7, 8};
      7'b0000011: q = '{0, 1, 2, 3, 4};
      7'b0100011: q = '{0, 1, 2, 5};
      7'b1100011: q = '{0, 1, 9};
      7'b1101111: q = '{0, 1, 10};
      default:    q = '{0, 1, 11};
    endcase
  endfunction

  initial begin
    logic [6:0] ops[7];
    int cnt, pcw, rw, memrd_cyc, waits, ph;
    logic done, okflag, hit;
    int q[$];

    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
            7'b1100011, 7'b1101111, 7'b1100111};
    vecs[0] = '{7'b0110011, 1'b0, 4, 1, 1};
    vecs[1] = '{7'b0010011, 1'b0, 4, 1, 1};
    vecs[2] = '{7'b0000011, 1'b0, 5, 1, 1};
    vecs[3] = '{7'b0100011, 1'b0, 4, 1, 0};
    vecs[4] = '{7'b1100011, 1'b1, 3, 2, 0};
    vecs[5] = '{7'b1100011, 1'b0, 3, 1, 0};
    vecs[6] = '{7'b1101111, 1'b0, 3, 2, 1};
    vecs[7] = '{7'b1100111, 1'b1, 3, 2, 1};

    // Reset state
    rst_n = 1'b0; opcode_i = '0; zero_i = 1'b0; mem_ready_i = 1'b0;
    #1;
    chk("reset_state", 32'(state_o), 32'd0);
    chk("reset_illegal", 32'(illegal_o), 32'd0);
    chk("reset_outputs", 32'(w_act), 32'(exp_out(0, 1'b0, 1'b0)));
    tick();
    tick();
    rst_n = 1'b1;

    // Table of single instructions with ready tied high
    for (int v = 0; v < 8; v++) begin
      cnt = 0; pcw = 0; rw = 0; done = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
        opcode_i = vecs[v].op; zero_i = vecs[v].z; mem_ready_i = 1'b1;
        #1;
        cnt++;
        pcw += int'(PCWrite_o);
        rw  += int'(RegWrite_o);
        done = instr_done_o;
        tick();
      end
      chk($sformatf("vec%0d_done", v), 32'(done), 32'd1);
      chk($sformatf("vec%0d_cycles", v), 32'(cnt), 32'(vecs[v].cyc));
      chk($sformatf("vec%0d_pcwrite", v), 32'(pcw), 32'(vecs[v].npcw));
      chk($sformatf("vec%0d_regwrite", v), 32'(rw), 32'(vecs[v].nrw));
    end

    // Load with three wait cycles in MEMRD: 8 cycles total
    cnt = 0; memrd_cyc = 0; done = 1'b0; okflag = 1'b1;
    for (int c = 0; c < 20 && !done; c++) begin
      opcode_i = 7'b0000011;
      mem_ready_i = !(state_o == 4'd3 && memrd_cyc < 3);
      #1;
      cnt++;
      if (state_o == 4'd3) begin
        memrd_cyc++;
        if (!(MemRead_o && IorD_o)) okflag = 1'b0;
      end
      if (state_o == 4'd4 && MemtoReg_o != 2'b01) okflag = 1'b0;
      done = instr_done_o;
      tick();
    end
    chk("load_wait_cycles", 32'(cnt), 32'd8);
    chk("load_wait_memrd_len", 32'(memrd_cyc), 32'd4);
    chk("load_wait_outputs", 32'(okflag), 32'd1);

    // Randomized instruction stream against the phase-list model
    for (int n = 0; n < 150; n++) begin
      opcode_i = ops[$urandom_range(0, 6)];
      phases(opcode_i, q);
      waits = 0;
      while (q.size() > 0) begin
        ph = q[0];
        zero_i = 1'($urandom);
        if (ph == 0 || ph == 3 || ph == 5)
          mem_ready_i = (waits >= 4) ? 1'b1 : ($urandom_range(0, 2) != 0);
        else
          mem_ready_i = 1'($urandom);
        #1;
        chk("rand_state", 32'(state_o), 32'(ph));
        chk("rand_outputs", 32'(w_act), 32'(exp_out(ph, mem_ready_i, zero_i)));
        if ((ph == 0 || ph == 3 || ph == 5) && !mem_ready_i) begin
          waits++;
        end else begin
          void'(q.pop_front());
          waits = 0;
        end
        tick();
      end
    end

    // Illegal opcode: held in ILLEGAL until reset
    opcode_i = 7'b0000000; mem_ready_i = 1'b1;
    tick();
    tick();
    okflag = 1'b1;
    for (int c = 0; c < 22; c++) begin
      mem_ready_i = 1'($urandom); zero_i = 1'($urandom);
      #1;
      if (state_o != 4'd12 || w_act != exp_out(12, mem_ready_i, zero_i)) okflag = 1'b0;
      tick();
    end
    chk("illegal_hold", 32'(okflag), 32'd1);
    chk("illegal_flag", 32'(illegal_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("illegal_reset_state", 32'(state_o), 32'd0);
    chk("illegal_reset_flag", 32'(illegal_o), 32'd0);
    tick();
    rst_n = 1'b1;

    // Memory timeout in FETCH: counter reaches 15 while still waiting
    mem_ready_i = 1'b0; opcode_i = 7'b0110011;
    okflag = 1'b1;
    for (int c = 0; c < 16; c++) begin
      #1;
      if (state_o != 4'd0 || w_act != exp_out(0, 1'b0, zero_i)) okflag = 1'b0;
      tick();
    end
    chk("timeout_fetch_hold", 32'(okflag), 32'd1);
    #1;
    chk("timeout_state", 32'(state_o), 32'd12);
    chk("timeout_flag", 32'(illegal_o), 32'd1);
    do_reset();

    // Reset dropped during MEMWR aborts the write asynchronously
    opcode_i = 7'b0100011; mem_ready_i = 1'b1; hit = 1'b0;
    for (int c = 0; c < 10 && !hit; c++) begin
      if (state_o == 4'd5) hit = 1'b1;
      else tick();
    end
    chk("memwr_reached", 32'(hit), 32'd1);
    mem_ready_i = 1'b0;
    #1;
    chk("memwr_write_high", 32'(MemWrite_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("memwr_reset_write", 32'(MemWrite_o), 32'd0);
    chk("memwr_reset_state", 32'(state_o), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
